seg7_scan_ctrl: RTL and testbench

Memory-mapped controller for the board's 8-digit, common-anode seven-segment display. The CPU writes a 32-bit value whenever the address decoder raises `seg7_cs` for 0x10010000 with a store in progress. The block latches that value and time-multiplexes its eight hex nibbles onto the shared segment bus, one digit at a time. It sits between the CPU data bus / IO decoder and the FPGA display pins.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 93 +++++++++
 tb/tb_seg7_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment pattern table for the 8-digit seven-segment controller.
package seg7_pkg;

   localparam logic [31:0] SEG7_ADDR   = 32'h1001_0000;
   localparam int unsigned SEG7_DIGITS = 8;
   localparam int unsigned NIB_W       = 4;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned SEG_W       = 7;
   localparam int unsigned DATA_W      = 32;

   localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first (F,E,d,C,b,A,9..0).
   localparam logic [15:0][SEG_W-1:0] HEX_SEG_TBL = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // Index of the most significant non-zero nibble; 0 when the whole value is zero.
   function automatic logic [IDX_W-1:0] msd_idx(input logic [DATA_W-1:0] v);
      logic [IDX_W-1:0] m;
      m = '0;
      for (int i = 0; i < int'(SEG7_DIGITS); i++) begin
         if (v[NIB_W*i +: NIB_W] != 4'h0) m = IDX_W'(i);
      end
      return m;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [NIB_W-1:0] nib,
   output logic [SEG_W-1:0] seg_c
);

   assign seg_c = HEX_SEG_TBL[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped 8-digit seven-segment scan controller.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned CLK_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seg7_cs,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [7:0]        an,
   output logic [SEG_W-1:0]  seg,
   output logic              dp
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned AN_W  = SEG7_DIGITS;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   logic [DATA_W-1:0] disp_q, disp_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              scan_on_q, scan_on_d;
   logic [AN_W-1:0]   an_q, an_d;
   logic [SEG_W-1:0]  seg_q, seg_d;

   logic              tick_c;
   logic              lit_c;
   logic [NIB_W-1:0]  nib_c;
   logic [SEG_W-1:0]  dec_seg_c;

   seg7_hex_decode u_dec (
      .nib   (nib_c),
      .seg_c (dec_seg_c)
   );

   always_comb begin
      disp_d    = disp_q;
      div_d     = div_q + DIV_W'(1);
      idx_d     = idx_q;
      scan_on_d = scan_on_q;
      an_d      = '1;
      seg_d     = SEG_OFF;

      if (seg7_cs && we) disp_d = wdata;

      tick_c = (div_q == DIV_MAX);
      if (tick_c) begin
         div_d     = '0;
         scan_on_d = 1'b1;
         // The enabling tick itself leaves the index at digit 0.
         if (scan_on_q) idx_d = idx_q + IDX_W'(1);
      end

      nib_c = disp_q[{idx_q, 2'b00} +: NIB_W];
`ifdef SEG7_LZB_EN
      lit_c = scan_on_q && (idx_q <= msd_idx(disp_q));
`else
      lit_c = scan_on_q;
`endif
      if (lit_c) begin
         an_d  = ~(AN_W'(1) << idx_q);
         seg_d = dec_seg_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q    <= '0;
         div_q     <= '0;
         idx_q     <= '0;
         scan_on_q <= 1'b0;
         an_q      <= '1;
         seg_q     <= SEG_OFF;
      end else begin
         disp_q    <= disp_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
         scan_on_q <= scan_on_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = 1'b1;
   assign rdata = seg7_cs ? disp_q : '0;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: three controllers (CLK_DIV 4, 2, 1) against a cycle-count display model.
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seg7_cs = 1'b0;
   logic        we = 1'b0;
   logic [31:0] wdata = '0;

   logic [31:0] rdata4, rdata2, rdata1;
   logic [7:0]  an4, an2, an1;
   logic [6:0]  seg4, seg2, seg1;
   logic        dp4, dp2, dp1;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int DIVS [3] = '{4, 2, 1};
`ifdef SEG7_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.CLK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .seg7_cs(seg7_cs), .we(we), .wdata(wdata),
      .rdata(rdata4), .an(an4), .seg(seg4), .dp(dp4));
   seg7_scan_ctrl #(.CLK_DIV(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .seg7_cs(seg7_cs), .we(we), .wdata(wdata),
      .rdata(rdata2), .an(an2), .seg(seg2), .dp(dp2));
   seg7_scan_ctrl #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .seg7_cs(seg7_cs), .we(we), .wdata(wdata),
      .rdata(rdata1), .an(an1), .seg(seg1), .dp(dp1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Segments lit per hex digit (active-high gfedcba), inverted for the active-low pins.
   function automatic logic [6:0] ref_seg(input logic [3:0] h);
      logic [6:0] on;
      case (h)
         4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
         4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
         4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
         4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
      endcase
      return ~on;
   endfunction

   // Expected pins after edge n (counted from reset release), given the value held before that edge.
   task automatic model_out(input int n, input int div, input logic [31:0] d,
                            output logic [7:0] an_o, output logic [6:0] seg_o);
      int slot;
      int top;
      an_o  = 8'hFF;
      seg_o = 7'h7F;
      if (n - 1 >= div) begin
         slot = ((n - 1) / div - 1) % 8;
         top  = 0;
         for (int i = 0; i < 8; i++) if (d[4*i +: 4] != 4'h0) top = i;
         if (!LZB || slot <= top) begin
            an_o  = ~(8'(1) << slot);
            seg_o = ref_seg(d[4*slot +: 4]);
         end
      end
   endtask

   int          m_n = 0;
   logic [31:0] m_disp = '0;
   logic [7:0]  e_an  [3] = '{default: 8'hFF};
   logic [6:0]  e_seg [3] = '{default: 7'h7F};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n    = 0;
         m_disp = '0;
         for (int i = 0; i < 3; i++) begin
            e_an[i]  = 8'hFF;
            e_seg[i] = 7'h7F;
         end
      end else begin
         m_n++;
         for (int i = 0; i < 3; i++) model_out(m_n, DIVS[i], m_disp, e_an[i], e_seg[i]);
         if (seg7_cs && we) m_disp = wdata;
      end
   end

   // Every cycle: all three controllers against the model.
   always @(negedge clk) begin
      logic [31:0] e_rd;
      e_rd = seg7_cs ? m_disp : 32'h0;
      check("an_div4", {24'h0, an4}, {24'h0, e_an[0]});
      check("seg_div4", {25'h0, seg4}, {25'h0, e_seg[0]});
      check("an_div2", {24'h0, an2}, {24'h0, e_an[1]});
      check("seg_div2", {25'h0, seg2}, {25'h0, e_seg[1]});
      check("an_div1", {24'h0, an1}, {24'h0, e_an[2]});
      check("seg_div1", {25'h0, seg1}, {25'h0, e_seg[2]});
      check("dp_all", {29'h0, dp4, dp2, dp1}, 32'h7);
      check("rdata_div4", rdata4, e_rd);
      check("rdata_div2", rdata2, e_rd);
      check("rdata_div1", rdata1, e_rd);
   end

   // Advance k edges; inputs always change 2 time units after an active edge.
   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   task automatic do_write(input logic [31:0] d);
      seg7_cs = 1'b1;
      we      = 1'b1;
      wdata   = d;
      cyc(1);
      seg7_cs = 1'b0;
      we      = 1'b0;
   endtask

   // Called just after reset release: blank for 4 edges, then digit 0 shows "0".
   task automatic expect_start();
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         check("start_blank_an", {24'h0, an4}, 32'hFF);
         check("start_blank_seg", {25'h0, seg4}, 32'h7F);
         if (k == 1) check("div1_blank_an", {24'h0, an1}, 32'hFF);
         if (k == 2) check("div1_first_an", {24'h0, an1}, 32'hFE);
      end
      @(posedge clk); #1;
      check("first_lit_an", {24'h0, an4}, 32'hFE);
      check("first_lit_seg", {25'h0, seg4}, 32'h40);
      #1;
   endtask

   initial begin
      logic [6:0] slot_pat [8];
      bit         found;
      int unsigned r;

      slot_pat = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};

      // Reset state.
      cyc(3);
      check("rst_an", {24'h0, an4}, 32'hFF);
      check("rst_seg", {25'h0, seg4}, 32'h7F);
      seg7_cs = 1'b1; #1;
      check("rst_rdata", rdata4, 32'h0);
      seg7_cs = 1'b0; #1;
      cyc(1);
      rst_n = 1'b1;
      expect_start();

      // Write and readback.
      do_write(32'h1234ABCD);
      seg7_cs = 1'b1; #1;
      check("rdata_sel", rdata4, 32'h1234ABCD);
      seg7_cs = 1'b0; #1;
      check("rdata_unsel", rdata4, 32'h0);

      // Align to the start of a digit-0 slot, then walk a full refresh.
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(posedge clk); #1;
         if (an4 != 8'hFE) found = 1'b1;
      end
      check("align_leave_d0", 32'(found), 32'h1);
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(posedge clk); #1;
         if (an4 == 8'hFE) found = 1'b1;
      end
      check("align_enter_d0", 32'(found), 32'h1);
      for (int c = 0; c < 32; c++) begin
         check($sformatf("walk_an_c%0d", c), {24'h0, an4}, {24'h0, ~(8'(1) << (c / 4))});
         check($sformatf("walk_seg_c%0d", c), {25'h0, seg4}, {25'h0, slot_pat[c / 4]});
         @(posedge clk); #1;
      end
      #1;

      // Select without store must not change the held value.
      seg7_cs = 1'b1;
      wdata   = 32'hFFFF_FFFF;
      cyc(5);
      check("nowrite_rdata", rdata4, 32'h1234ABCD);
      seg7_cs = 1'b0;

      // Store landing on a slot-advance edge of the CLK_DIV=4 instance.
      for (int i = 0; i < 8 && ((m_n + 1) % 4) != 0; i++) cyc(1);
      do_write(32'h89AB_CDEF);
      cyc(40);

      // Asynchronous reset while digit 5 is lit.
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         if (e_an[0] == 8'hDF) found = 1'b1;
         else cyc(1);
      end
      check("reach_digit5", 32'(found), 32'h1);
      rst_n = 1'b0; #1;
      check("async_an", {24'h0, an4}, 32'hFF);
      check("async_seg", {25'h0, seg4}, 32'h7F);
      check("async_an_div1", {24'h0, an1}, 32'hFF);
      seg7_cs = 1'b1; #1;
      check("async_rdata", rdata4, 32'h0);
      seg7_cs = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      expect_start();

      // Small values exercise leading zeros.
      do_write(32'h0000_00A5);
      cyc(40);
      do_write(32'h0);
      cyc(40);

      // Random traffic with occasional mid-cycle reset pulses.
      for (int i = 0; i < 1500; i++) begin
         r       = $urandom;
         seg7_cs = (r % 3) == 0;
         we      = r[4];
         wdata   = $urandom >> (4 * $urandom_range(0, 8));
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            #4;
            rst_n = 1'b1;
         end
         cyc(1);
      end
      seg7_cs = 1'b0;
      we      = 1'b0;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
